// File: rtl/freq_meter_pkg.sv
// Shared FSM state type and default parameter values for the freq_meter block.
package freq_meter_pkg;

    localparam logic [31:0] GATE_CYCLES_DEF = 32'd10_000_000;
    localparam int          CNT_W_DEF       = 32;
    localparam int          SYNC_STAGES_DEF = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_e;

endpackage

// File: rtl/freq_meter_sync.sv
// Synchronizer chain for the asynchronous sig_i followed by a registered rising-edge detector.
module freq_meter_sync
    import freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic edge_p
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   edge_r;

    // Shift sig_i through the chain; the pulse is registered, landing SYNC_STAGES+1 cycles after the rise
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_r <= '0;
            prev_r <= 1'b0;
            edge_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sig_i};
            prev_r <= sync_r[SYNC_STAGES-1];
            edge_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
        end
    end

    assign edge_p = edge_r;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts sig_i rising edges over GATE_CYCLES clk_i cycles.
// Optional period_o output is enabled by defining FREQ_METER_PERIOD_EN.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter logic [31:0] GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int          SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sig_i,
    input  logic             start_i,
    input  logic             cont_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] count_o,
    output logic             valid_o,
    output logic             ovf_o
`ifdef FREQ_METER_PERIOD_EN
    ,
    output logic [CNT_W-1:0] period_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [31:0]      GATE_LAST = GATE_CYCLES - 32'd1;

    logic             edge_s;
    state_e           state_r;
    logic [31:0]      gate_cnt_r;
    logic [CNT_W-1:0] edge_cnt_r;
    logic             ovf_flag_r;
    logic [CNT_W-1:0] count_r;
    logic             ovf_r;
    logic             valid_r;
    logic             last_s;
    logic [CNT_W-1:0] next_cnt_s;
    logic             next_ovf_s;

    freq_meter_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .sig_i (sig_i),
        .edge_p(edge_s)
    );

    assign last_s = (gate_cnt_r == GATE_LAST);

    // Edge count and overflow as they stand after this cycle's edge_p, saturating at CNT_MAX
    always_comb begin
        next_cnt_s = edge_cnt_r;
        next_ovf_s = ovf_flag_r;
        if (edge_s) begin
            if (edge_cnt_r == CNT_MAX) begin
                next_cnt_s = edge_cnt_r;
                next_ovf_s = 1'b1;
            end else begin
                next_cnt_s = edge_cnt_r + CNT_W'(1'b1);
                next_ovf_s = ovf_flag_r;
            end
        end else begin
            next_cnt_s = edge_cnt_r;
            next_ovf_s = ovf_flag_r;
        end
    end

    // Window FSM; the last cycle publishes the result and re-arms at once when cont_i is high
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            gate_cnt_r <= 32'd0;
            edge_cnt_r <= '0;
            ovf_flag_r <= 1'b0;
            count_r    <= '0;
            ovf_r      <= 1'b0;
            valid_r    <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_i || cont_i) begin
                        state_r    <= GATE;
                        gate_cnt_r <= 32'd0;
                        edge_cnt_r <= '0;
                        ovf_flag_r <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GATE: begin
                    if (last_s) begin
                        count_r    <= next_cnt_s;
                        ovf_r      <= next_ovf_s;
                        valid_r    <= 1'b1;
                        gate_cnt_r <= 32'd0;
                        edge_cnt_r <= '0;
                        ovf_flag_r <= 1'b0;
                        state_r    <= cont_i ? GATE : IDLE;
                    end else begin
                        gate_cnt_r <= gate_cnt_r + 32'd1;
                        edge_cnt_r <= next_cnt_s;
                        ovf_flag_r <= next_ovf_s;
                        state_r    <= GATE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy_o  = (state_r == GATE);
    assign count_o = count_r;
    assign ovf_o   = ovf_r;
    assign valid_o = valid_r;

`ifdef FREQ_METER_PERIOD_EN
    logic [CNT_W-1:0] per_cnt_r;
    logic [CNT_W-1:0] period_r;

    // Free-running cycles since the previous edge_p, captured into period_r on every edge_p
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            per_cnt_r <= '0;
            period_r  <= '0;
        end else if (edge_s) begin
            period_r  <= per_cnt_r;
            per_cnt_r <= CNT_W'(1'b1);
        end else if (per_cnt_r != CNT_MAX) begin
            per_cnt_r <= per_cnt_r + CNT_W'(1'b1);
        end else begin
            per_cnt_r <= per_cnt_r;
        end
    end

    assign period_o = period_r;
`endif

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 10_000_000, gate window length in clk_i cycles (1 s at 10 MHz); legal range 2..2^32-1.
REQ-002 SHALL have parameter CNT_W, default 32, width of the edge counter and result.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for sig_i; legal range 2..4.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port sig_i  input  1  asynchronous signal under measurement, e.g. a divided clock.
REQ-007 SHALL have port start_i  input  1  single-cycle request for one measurement.
REQ-008 SHALL have port cont_i  input  1  level; while high, windows repeat back-to-back.
REQ-009 SHALL have port busy_o  output  1  high while a window is open.
REQ-010 SHALL have port count_o  output  CNT_W  rising edges counted in the last completed window.
REQ-011 SHALL have port valid_o  output  1  one-cycle pulse when count_o updates.
REQ-012 SHALL have port ovf_o  output  1  last completed window saturated.

Function
REQ-013 SHALL pass sig_i through SYNC_STAGES flops, then a rising-edge detector producing edge_p, a one-cycle pulse SYNC_STAGES+1 cycles after the sig_i rise.
REQ-014 SHALL implement FSM states IDLE and GATE only.
REQ-015 IDLE -> GATE when start_i=1 or cont_i=1; gate counter and edge counter cleared on entry.
REQ-016 In GATE, gate counter SHALL increment each cycle; the window is exactly GATE_CYCLES cycles, the last being gate counter = GATE_CYCLES-1.
REQ-017 edge_p in any window cycle, including the first and the last, SHALL increment the edge counter.
REQ-018 Edge counter SHALL saturate at 2^CNT_W-1; any further edge in the window sets the internal overflow flag.
REQ-019 On the last window cycle: count_o <= edge count including that cycle's edge_p, ovf_o <= overflow flag, valid_o = 1 on the following cycle only.
REQ-020 After the last cycle, next state SHALL be GATE with counters cleared if cont_i=1, else IDLE; no dead cycle between continuous windows.
REQ-021 start_i while in GATE SHALL be ignored; dropping cont_i mid-window SHALL let the current window complete.
REQ-022 busy_o SHALL equal (state == GATE).
REQ-023 count_o and ovf_o SHALL hold their values between valid_o pulses.

Reset
REQ-024 rst_i=1 SHALL immediately force state IDLE, clear all counters and synchronizer flops, and set count_o=0, valid_o=0, ovf_o=0, busy_o=0.
REQ-025 Reset mid-window SHALL discard the partial window; no valid_o pulse produced.
REQ-026 First measurement after reset release SHALL require a fresh start_i or cont_i.

Configuration
REQ-027 Macro FREQ_METER_PERIOD_EN SHALL, when defined, add output period_o (CNT_W): clk_i cycles between the last two edge_p pulses, updated on each edge_p, saturating at 2^CNT_W-1, reset 0, counting in all states.
REQ-028 Without FREQ_METER_PERIOD_EN, period_o and its counter SHALL not exist; all other behaviour is identical.

Structure
REQ-029 Package freq_meter_pkg SHALL hold the FSM state typedef and default parameter constants.
REQ-030 Sub-module freq_meter_sync SHALL contain the synchronizer chain and edge detector, output edge_p.

Verification
REQ-031 GATE_CYCLES=100, sig_i period 10 clk, start_i pulse -> one valid_o, count_o=10, ovf_o=0, busy_o high exactly 100 cycles.
REQ-032 CNT_W=4, GATE_CYCLES=100, sig_i period 4 clk -> count_o=15, ovf_o=1.
REQ-033 Single sig_i rise timed so edge_p lands on the last window cycle -> count_o=1; timed one cycle later -> count_o=0.
REQ-034 cont_i held high, sig_i period 10, GATE_CYCLES=100 -> valid_o every 100 cycles, each count_o=10, busy_o never drops.
REQ-035 rst_i asserted at window cycle 50 -> outputs zero immediately, no valid_o; subsequent start_i gives correct count.
REQ-036 FREQ_METER_PERIOD_EN defined, sig_i period 7 clk -> period_o=7 after the second edge; start_i during busy ignored.
